// File: rtl/crc8_byte_serializer.sv
// Byte-to-bit serializer feeding a bit-serial CRC-8 generator; captures the
// generator's result once per frame after a fixed pipeline latency.
module crc8_byte_serializer #(
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned CRC_LAT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       bit_last,
    input  logic [7:0] crc_in,
    output logic [7:0] frame_crc,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CRC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_SHIFT,
        S_STALL,
        S_WAIT_CRC
    } state_e;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   shreg_q, shreg_d;
    logic                last_q, last_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   frame_crc_q, frame_crc_d;
    logic                frame_done_q, frame_done_d;
    logic                byte_ready_q, byte_ready_d;
    logic                bit_out_q, bit_out_d;
    logic                bit_valid_q, bit_valid_d;
    logic                bit_last_q, bit_last_d;
    logic                busy_q, busy_d;
    logic                shift_d;
    logic                accept;

    // idx counts bits already presented; map it onto the physical bit position
    function automatic logic [IDX_W-1:0] bit_pos(input logic [IDX_W-1:0] idx);
        return (MSB_FIRST != 0) ? (IDX_LAST - idx) : idx;
    endfunction

    assign accept = byte_valid && byte_ready_q;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        last_d       = last_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_crc_d  = frame_crc_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d = byte_in;
                    last_d  = byte_last;
                    state_d = S_WAKE;
                end
            end
            S_WAKE: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // index wraps to zero after the 8th bit in every branch
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    if (last_q) begin
                        state_d = S_WAIT_CRC;
                        cnt_d   = CNT_LOAD;
                    end else if (accept) begin
                        shreg_d = byte_in;
                        last_d  = byte_last;
                    end else begin
                        state_d = S_STALL;
                    end
                end
            end
            S_STALL: begin
                if (accept) begin
                    shreg_d = byte_in;
                    last_d  = byte_last;
                    state_d = S_SHIFT;
                end
            end
            S_WAIT_CRC: begin
                if (cnt_q == '0) begin
                    frame_crc_d  = crc_in;
                    frame_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // outputs are registered, so they are decoded from the next state
        shift_d      = (state_d == S_SHIFT);
        bit_valid_d  = (state_d == S_WAKE) || shift_d;
        bit_out_d    = shift_d && shreg_d[bit_pos(idx_d)];
        bit_last_d   = shift_d && (idx_d == IDX_LAST) && last_d;
        byte_ready_d = (state_d == S_IDLE) || (state_d == S_STALL)
                       || (shift_d && (idx_d == IDX_LAST) && !last_d);
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            frame_crc_q  <= '0;
            frame_done_q <= 1'b0;
            byte_ready_q <= 1'b0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            bit_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            frame_crc_q  <= frame_crc_d;
            frame_done_q <= frame_done_d;
            byte_ready_q <= byte_ready_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            bit_last_q   <= bit_last_d;
            busy_q       <= busy_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign bit_last   = bit_last_q;
    assign frame_crc  = frame_crc_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_crc8_byte_serializer.sv
// Bench for crc8_byte_serializer: an MSB-first instance chained to a CRC-8
// generator model, plus an LSB-first instance with a longer capture latency.
module tb_crc8_byte_serializer;

    localparam int unsigned LAT_A = 2;
    localparam int unsigned LAT_B = 3;

    typedef struct packed { logic b; logic l; logic r; } bit_exp_t;
    typedef struct packed { logic [7:0] crc; logic [7:0] nvalid; logic [7:0] nstall; } frame_exp_t;
    typedef struct packed {
        logic [3:0]      n;
        logic [8:0][7:0] data;
        logic [3:0]      gap;
        logic [7:0]      exp_valid;
        logic [7:0]      exp_stall;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in_a, byte_in_b;
    logic       byte_valid_a, byte_valid_b, byte_last_a, byte_last_b;
    logic       byte_ready_a, byte_ready_b;
    logic       bit_out_a, bit_out_b, bit_valid_a, bit_valid_b, bit_last_a, bit_last_b;
    logic [7:0] crc_in_a, crc_in_b;
    logic [7:0] frame_crc_a, frame_crc_b;
    logic       frame_done_a, frame_done_b, busy_a, busy_b;
    logic [7:0] gen_crc;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    crc8_byte_serializer #(.MSB_FIRST(1), .CRC_LAT(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .byte_in(byte_in_a), .byte_valid(byte_valid_a),
        .byte_last(byte_last_a), .byte_ready(byte_ready_a), .bit_out(bit_out_a),
        .bit_valid(bit_valid_a), .bit_last(bit_last_a), .crc_in(crc_in_a),
        .frame_crc(frame_crc_a), .frame_done(frame_done_a), .busy(busy_a)
    );

    crc8_byte_serializer #(.MSB_FIRST(0), .CRC_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .byte_in(byte_in_b), .byte_valid(byte_valid_b),
        .byte_last(byte_last_b), .byte_ready(byte_ready_b), .bit_out(bit_out_b),
        .bit_valid(bit_valid_b), .bit_last(bit_last_b), .crc_in(crc_in_b),
        .frame_crc(frame_crc_b), .frame_done(frame_done_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic d);
        logic fb;
        fb = c[7] ^ d;
        return {c[6:0], 1'b0} ^ (fb ? 8'h49 : 8'h00);
    endfunction

    // byte-wise golden CRC-8: poly 0x49, init 0x00, xorout 0xFF, MSB first
    function automatic logic [7:0] golden(input vec_t v);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < int'(v.n); k++) begin
            c = c ^ v.data[k];
            for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h49) : (c << 1);
        end
        return c ^ 8'hFF;
    endfunction

    // downstream bit-serial generator: result one cycle after last_bit
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_crc  <= 8'h00;
            crc_in_a <= 8'h00;
        end else if (bit_valid_a) begin
            if (bit_last_a) begin
                crc_in_a <= crc_step(gen_crc, bit_out_a) ^ 8'hFF;
                gen_crc  <= 8'h00;
            end else begin
                gen_crc <= crc_step(gen_crc, bit_out_a);
            end
        end
    end

    bit_exp_t   bq[$];
    frame_exp_t fq[$];
    bit_exp_t   mon_e;
    frame_exp_t mon_f;
    int         nvalid, nstall, since_last;
    bit         in_wait;
    logic [7:0] held_crc;

    always @(negedge clk) begin
        if (rst) begin
            bq.delete();
            fq.delete();
            nvalid = 0; nstall = 0; since_last = 0; in_wait = 0; held_crc = 8'h00;
        end else begin
            if (in_wait) since_last++;
            if (bit_valid_a) begin
                nvalid++;
                if (bq.size() == 0) check("bit_unexpected", 32'(1), 32'(0));
                else begin
                    mon_e = bq.pop_front();
                    check("bit_out_last_ready", 32'({bit_out_a, bit_last_a, byte_ready_a}), 32'(mon_e));
                end
                if (bit_last_a) begin in_wait = 1; since_last = 0; end
            end else begin
                check("idle_bits_zero", 32'({bit_out_a, bit_last_a}), 32'(0));
                if (busy_a && byte_ready_a) nstall++;
            end
            if (frame_done_a) begin
                if (fq.size() == 0) check("frame_done_unexpected", 32'(1), 32'(0));
                else begin
                    mon_f = fq.pop_front();
                    check("frame_crc", 32'(frame_crc_a), 32'(mon_f.crc));
                    check("valid_cycles", 32'(nvalid), 32'(mon_f.nvalid));
                    check("stall_cycles", 32'(nstall), 32'(mon_f.nstall));
                    check("done_latency", 32'(since_last), 32'(LAT_A + 1));
                    held_crc = mon_f.crc;
                end
                nvalid = 0; nstall = 0; in_wait = 0; since_last = 0;
            end else begin
                check("frame_crc_hold", 32'(frame_crc_a), 32'(held_crc));
            end
        end
    end

    task automatic wait_ready_a(output bit ok);
        ok = 0;
        for (int t = 0; t < 40; t++) begin
            if (byte_ready_a) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic last, input logic first);
        bit_exp_t e;
        bit ok;
        if (first) begin
            e = '0;
            bq.push_back(e);
        end
        for (int i = 0; i < 8; i++) begin
            e.b = d[7-i];
            e.l = last && (i == 7);
            e.r = !last && (i == 7);
            bq.push_back(e);
        end
        byte_in_a = d; byte_last_a = last; byte_valid_a = 1'b1;
        wait_ready_a(ok);
        check("accept", 32'(ok), 32'(1));
        @(negedge clk);
    endtask

    task automatic run_frame(input vec_t v);
        frame_exp_t f;
        bit ok;
        f.crc = golden(v); f.nvalid = v.exp_valid; f.nstall = v.exp_stall;
        fq.push_back(f);
        for (int k = 0; k < int'(v.n); k++) begin
            if (k > 0 && v.gap != 0) begin
                byte_valid_a = 1'b0;
                wait_ready_a(ok);
                check("bit8_reached", 32'(ok), 32'(1));
                repeat (int'(v.gap)) @(negedge clk);
            end
            send_a(v.data[k], k == int'(v.n) - 1, k == 0);
        end
        byte_valid_a = 1'b0; byte_last_a = 1'b0;
        for (int t = 0; t < 200 && fq.size() != 0; t++) @(negedge clk);
        check("frame_completed", 32'(fq.size()), 32'(0));
    endtask

    vec_t       vecs[6];
    logic [2:0] exp_b[9];

    initial begin
        rst = 1'b1;
        byte_in_a = 8'h00; byte_valid_a = 1'b0; byte_last_a = 1'b0;
        byte_in_b = 8'h00; byte_valid_b = 1'b0; byte_last_b = 1'b0;
        crc_in_b = 8'hEE;

        for (int i = 0; i < 6; i++) vecs[i] = '0;
        vecs[0].n = 1; vecs[0].data[0] = 8'h31; vecs[0].exp_valid = 9;
        vecs[1].n = 2; vecs[1].data[0] = 8'hA5; vecs[1].data[1] = 8'h3C; vecs[1].exp_valid = 17;
        vecs[2] = vecs[1]; vecs[2].gap = 3; vecs[2].exp_stall = 3;
        vecs[3].n = 9; vecs[3].exp_valid = 73;
        for (int k = 0; k < 9; k++) vecs[3].data[k] = 8'(8'h31 + k);
        vecs[4].n = 1; vecs[4].data[0] = 8'h00; vecs[4].exp_valid = 9;
        vecs[5].n = 3; vecs[5].data[0] = 8'hFF; vecs[5].data[1] = 8'h00; vecs[5].data[2] = 8'h81;
        vecs[5].gap = 1; vecs[5].exp_valid = 25; vecs[5].exp_stall = 2;

        exp_b[0] = 3'b100; exp_b[1] = 3'b110;
        for (int i = 2; i < 8; i++) exp_b[i] = 3'b100;
        exp_b[8] = 3'b101;

        // reset values, and byte_ready rising on the first edge after release
        repeat (2) @(negedge clk);
        check("rst_outputs_a", 32'({byte_ready_a, bit_out_a, bit_valid_a, bit_last_a, frame_done_a, busy_a, frame_crc_a}), 32'(0));
        check("rst_outputs_b", 32'({byte_ready_b, bit_out_b, bit_valid_b, bit_last_b, frame_done_b, busy_b, frame_crc_b}), 32'(0));
        rst = 1'b0;
        #1 check("ready_before_edge", 32'(byte_ready_a), 32'(0));
        @(posedge clk);
        #1 check("ready_after_edge", 32'({byte_ready_a, byte_ready_b}), 32'(2'b11));
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // reset during the 5th data bit aborts the frame
        send_a(8'hC3, 1'b1, 1'b1);
        byte_valid_a = 1'b0; byte_last_a = 1'b0;
        repeat (5) @(negedge clk);
        check("bit5_on_wire", 32'({busy_a, bit_valid_a}), 32'(2'b11));
        #2 rst = 1'b1;
        #1 check("abort_outputs", 32'({byte_ready_a, bit_out_a, bit_valid_a, bit_last_a, frame_done_a, busy_a, frame_crc_a}), 32'(0));
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'({frame_done_a, busy_a}), 32'(0));
        rst = 1'b0;
        @(posedge clk);
        #1 check("ready_after_abort", 32'(byte_ready_a), 32'(1));
        @(negedge clk);
        run_frame(vecs[0]);
        run_frame(vecs[3]);
        run_frame(vecs[4]);

        // LSB-first instance: byte 0x01 and capture exactly LAT_B+1 cycles after bit_last
        byte_in_b = 8'h01; byte_last_b = 1'b1; byte_valid_b = 1'b1;
        for (int t = 0; t < 40 && !byte_ready_b; t++) @(negedge clk);
        check("b_accept", 32'(byte_ready_b), 32'(1));
        @(negedge clk);
        byte_valid_b = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("b_serial", 32'({bit_valid_b, bit_out_b, bit_last_b}), 32'(exp_b[i]));
            @(negedge clk);
        end
        for (int i = 1; i <= int'(LAT_B) + 1; i++) begin
            if (i == int'(LAT_B)) crc_in_b = 8'h5A;
            check("b_done_timing", 32'(frame_done_b), 32'(i == int'(LAT_B) + 1));
            if (i <= int'(LAT_B)) @(negedge clk);
        end
        check("b_frame_crc", 32'(frame_crc_b), 32'(8'h5A));
        check("b_idle_ready", 32'({byte_ready_b, busy_b}), 32'(2'b10));
        crc_in_b = 8'h11;
        @(negedge clk);
        check("b_crc_hold", 32'({frame_crc_b, frame_done_b}), 32'({8'h5A, 1'b0}));

        check("queues_drained", 32'(bq.size() + fq.size()), 32'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
